// File: rtl/tftp_defs.sv
// Shared TFTP decode definitions: opcodes, FSM state encoding, field-flag bundle.
// Types and constants only; no timing or flow-control behaviour.
package tftp_defs;

  localparam int HDR_LEN_DEF = 42;

  localparam logic [7:0] OPC_RRQ   = 8'd1;
  localparam logic [7:0] OPC_WRQ   = 8'd2;
  localparam logic [7:0] OPC_DATA  = 8'd3;
  localparam logic [7:0] OPC_ACK   = 8'd4;
  localparam logic [7:0] OPC_ERROR = 8'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_OP_HI, S_OP_LO, S_BLK_HI, S_BLK_LO, S_ERR_HI,
    S_ERR_LO, S_FNAME, S_MODE, S_DATA, S_EMSG, S_DRAIN
  } state_t;

  typedef struct packed {
    logic opcode;
    logic blockno;
    logic errcode;
    logic filename;
    logic mode;
    logic data;
    logic errmsg;
  } fld_t;

endpackage

// File: rtl/tftp_str_field.sv
// Length counter and terminator detector for one NUL-terminated string field.
// term/overflow are combinational on the current byte; the count clears on clear.
module tftp_str_field #(
  parameter int MAX_STR = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       byte_valid,
  input  logic [7:0] eth_data,
  output logic       term,
  output logic       overflow
);

  localparam int LW = $clog2(MAX_STR + 1);
  localparam logic [LW-1:0] LAST_IDX = LW'(MAX_STR - 1);

  logic [LW-1:0] r_len;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_len <= '0;
    end else if (byte_valid) begin
      r_len <= r_len + 1'b1;
    end
  end

  // The MAX_STR-th byte overflows only if it is not itself the terminator.
  assign term     = byte_valid && (eth_data == 8'h00);
  assign overflow = byte_valid && (eth_data != 8'h00) && (r_len == LAST_IDX);

endmodule

// File: rtl/tftp_rx_field_decoder.sv
// Classifies each received frame byte into its TFTP field; one-cycle latency, all outputs
// registered. No backpressure: every byte_valid cycle is consumed, idle cycles hold state.
module tftp_rx_field_decoder
  import tftp_defs::*;
#(
  parameter int HDR_LEN = HDR_LEN_DEF,
  parameter int CNT_W   = 11,
  parameter int MAX_STR = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             byte_valid,
  input  logic [CNT_W-1:0] cnt,
  input  logic [7:0]       eth_data,
  input  logic             frame_end,
  output logic [7:0]       byte_q,
  output logic             byte_q_valid,
  output logic             idle_en,
  output logic             opcode_en,
  output logic             blockno_en,
  output logic             errcode_en,
  output logic             filename_en,
  output logic             mode_en,
  output logic             data_en,
  output logic             errmsg_en,
  output logic [2:0]       pkt_type,
  output logic             pkt_done,
  output logic             pkt_err
);

  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t     r_state;
  fld_t       r_fld;
  logic       r_err;
  logic [2:0] r_pkt_type;
  logic [7:0] r_byte_q;
  logic       r_byte_q_vld;
  logic       r_idle;
  logic       r_done;
  logic       r_perr;

  state_t w_cur;
  state_t w_next;
  fld_t   w_fld;
  logic   w_restart;
  logic   w_err_now;
  logic   w_trunc;
  logic   w_err_total;
  logic   w_str_active;
  logic   w_term;
  logic   w_ovf;

  // A cnt==1 byte is always treated as the first header byte, whatever state we were in.
  assign w_restart    = byte_valid && (cnt == CNT_ONE);
  assign w_cur        = w_restart ? S_HDR : r_state;
  assign w_str_active = w_cur inside {S_FNAME, S_MODE, S_EMSG};

  tftp_str_field #(.MAX_STR(MAX_STR)) u_str (
    .clk       (clk),
    .reset     (reset),
    .clear     (!w_str_active || w_term || w_ovf),
    .byte_valid(byte_valid && w_str_active),
    .eth_data  (eth_data),
    .term      (w_term),
    .overflow  (w_ovf)
  );

  always_comb begin
    w_next    = w_cur;
    w_fld     = '0;
    w_err_now = 1'b0;
    case (w_cur)
      S_HDR:    if (cnt == HDR_LAST) w_next = S_OP_HI;
      S_OP_HI: begin
        w_fld.opcode = 1'b1;
        if (eth_data != 8'h00) begin
          w_err_now = 1'b1;
          w_next    = S_DRAIN;
        end else begin
          w_next = S_OP_LO;
        end
      end
      S_OP_LO: begin
        w_fld.opcode = 1'b1;
        case (eth_data)
          OPC_RRQ, OPC_WRQ:  w_next = S_FNAME;
          OPC_DATA, OPC_ACK: w_next = S_BLK_HI;
          OPC_ERROR:         w_next = S_ERR_HI;
          default: begin
            w_err_now = 1'b1;
            w_next    = S_DRAIN;
          end
        endcase
      end
      S_BLK_HI: begin w_fld.blockno = 1'b1; w_next = S_BLK_LO; end
      S_BLK_LO: begin
        w_fld.blockno = 1'b1;
        w_next = (r_pkt_type == OPC_DATA[2:0]) ? S_DATA : S_DRAIN;
      end
      S_ERR_HI: begin w_fld.errcode = 1'b1; w_next = S_ERR_LO; end
      S_ERR_LO: begin w_fld.errcode = 1'b1; w_next = S_EMSG; end
      S_FNAME, S_MODE, S_EMSG: begin
        w_fld.filename = (w_cur == S_FNAME);
        w_fld.mode     = (w_cur == S_MODE);
        w_fld.errmsg   = (w_cur == S_EMSG);
        if (w_term) begin
          w_next = (w_cur == S_FNAME) ? S_MODE : S_DRAIN;
        end else if (w_ovf) begin
          w_err_now = 1'b1;
          w_next    = S_DRAIN;
        end
      end
      S_DATA:   w_fld.data = 1'b1;
      default:  w_next = w_cur;
    endcase
    if (frame_end) w_next = S_IDLE;
  end

  // A DATA packet may end right after its block number (empty payload).
  assign w_trunc = frame_end && !(w_cur inside {S_DATA, S_DRAIN, S_IDLE})
                   && !((w_cur == S_BLK_LO) && (r_pkt_type == OPC_DATA[2:0]));
  assign w_err_total = (r_err && !w_restart) || w_err_now || w_trunc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_fld        <= '0;
      r_err        <= 1'b0;
      r_pkt_type   <= '0;
      r_byte_q     <= '0;
      r_byte_q_vld <= 1'b0;
      r_idle       <= 1'b1;
      r_done       <= 1'b0;
      r_perr       <= 1'b0;
    end else begin
      r_byte_q_vld <= byte_valid;
      r_fld        <= '0;
      r_done       <= 1'b0;
      r_perr       <= 1'b0;
      if (byte_valid) begin
        r_byte_q <= eth_data;
        r_fld    <= w_fld;
        r_state  <= w_next;
        r_idle   <= (w_next == S_IDLE);
        r_err    <= frame_end ? 1'b0 : w_err_total;
        if (w_restart) r_pkt_type <= '0;
        if (w_cur == S_OP_LO) r_pkt_type <= eth_data[2:0];
        if (frame_end && (w_cur != S_IDLE)) begin
          r_done <= !w_err_total;
          r_perr <= w_err_total;
        end
      end
    end
  end

  assign byte_q       = r_byte_q;
  assign byte_q_valid = r_byte_q_vld;
  assign idle_en      = r_idle;
  assign opcode_en    = r_fld.opcode;
  assign blockno_en   = r_fld.blockno;
  assign errcode_en   = r_fld.errcode;
  assign filename_en  = r_fld.filename;
  assign mode_en      = r_fld.mode;
  assign data_en      = r_fld.data;
  assign errmsg_en    = r_fld.errmsg;
  assign pkt_type     = r_pkt_type;
  assign pkt_done     = r_done;
  assign pkt_err      = r_perr;

endmodule

// File: tb/tb_tftp_rx_field_decoder.sv
// Directed-vector bench for tftp_rx_field_decoder: builds frames byte by byte and checks
// per-byte field classification, end-of-packet pulses and reset behaviour.
module tb_tftp_rx_field_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic [10:0] cnt;
  logic [7:0]  eth_data;
  logic        frame_end;
  logic [7:0]  byte_q;
  logic        byte_q_valid, idle_en, opcode_en, blockno_en, errcode_en;
  logic        filename_en, mode_en, data_en, errmsg_en, pkt_done, pkt_err;
  logic [2:0]  pkt_type;

  tftp_rx_field_decoder dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .cnt(cnt), .eth_data(eth_data),
    .frame_end(frame_end), .byte_q(byte_q), .byte_q_valid(byte_q_valid), .idle_en(idle_en),
    .opcode_en(opcode_en), .blockno_en(blockno_en), .errcode_en(errcode_en),
    .filename_en(filename_en), .mode_en(mode_en), .data_en(data_en), .errmsg_en(errmsg_en),
    .pkt_type(pkt_type), .pkt_done(pkt_done), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  // Field codes: 0 none, 1 opcode, 2 blockno, 3 errcode, 4 filename, 5 mode, 6 data, 7 errmsg, 15 several.
  int n_vec = 0, n_miss = 0;
  int obs_cls [0:2047];
  int exp_cls [0:2047];
  logic [7:0] frm [$];
  int n_done, n_err, n_bq_bad, done_type, gap_bad;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int classify();
    int code = 0, n = 0;
    if (opcode_en)   begin code = 1; n++; end
    if (blockno_en)  begin code = 2; n++; end
    if (errcode_en)  begin code = 3; n++; end
    if (filename_en) begin code = 4; n++; end
    if (mode_en)     begin code = 5; n++; end
    if (data_en)     begin code = 6; n++; end
    if (errmsg_en)   begin code = 7; n++; end
    return (n > 1) ? 15 : code;
  endfunction

  task automatic clr_stats();
    n_done = 0; n_err = 0; n_bq_bad = 0; done_type = -1; gap_bad = 0;
    for (int i = 0; i < 2048; i++) begin obs_cls[i] = 0; exp_cls[i] = 0; end
  endtask

  task automatic set_exp(input int lo, input int hi, input int code);
    for (int i = lo; i <= hi; i++) exp_cls[i] = code;
  endtask

  task automatic drive_byte(input int c, input logic [7:0] d, input logic fe);
    byte_valid = 1'b1; cnt = 11'(c); eth_data = d; frame_end = fe;
    @(posedge clk); #1;
    byte_valid = 1'b0; frame_end = 1'b0;
    obs_cls[c] = classify();
    if (byte_q !== d || byte_q_valid !== 1'b1) n_bq_bad++;
    if (pkt_done) begin n_done++; done_type = int'(pkt_type); end
    if (pkt_err) n_err++;
  endtask

  task automatic run_frame(input int gap_at);
    for (int i = 0; i < frm.size(); i++) begin
      if (i + 1 == gap_at) begin
        @(posedge clk); #1;
        if (byte_q_valid !== 1'b0 || classify() != 0 || idle_en !== 1'b0) gap_bad++;
      end
      drive_byte(i + 1, frm[i], i == frm.size() - 1);
    end
  endtask

  task automatic cmp_frame(input string tag, input int len);
    int bad = 0;
    for (int i = 1; i <= len; i++) if (obs_cls[i] != exp_cls[i]) bad++;
    chk({tag, "_class_errs"}, bad, 0);
    chk({tag, "_byte_q_errs"}, n_bq_bad, 0);
  endtask

  task automatic push_hdr();
    frm.delete();
    for (int i = 0; i < 42; i++) frm.push_back(8'h5A);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) frm.push_back(s[i]);
    frm.push_back(8'h00);
  endtask

  task automatic pad_to(input int n);
    while (frm.size() < n) frm.push_back(8'h00);
  endtask

  task automatic build_rrq();
    push_hdr(); frm.push_back(8'h00); frm.push_back(8'h01);
    push_str("test.txt"); push_str("octet"); pad_to(62);
  endtask

  task automatic build_ack();
    push_hdr(); frm.push_back(8'h00); frm.push_back(8'h04);
    frm.push_back(8'h00); frm.push_back(8'h07); pad_to(60);
  endtask

  task automatic idle_after(input string tag);
    @(posedge clk); #1;
    chk({tag, "_idle_after"}, int'(idle_en), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; byte_valid = 1'b0; cnt = '0; eth_data = '0; frame_end = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idle_en", int'(idle_en), 1);
    chk("rst_flags", classify(), 0);
    chk("rst_byte_q_valid", int'(byte_q_valid), 0);
    chk("rst_byte_q", int'(byte_q), 0);
    chk("rst_pkt_type", int'(pkt_type), 0);
    chk("rst_pulses", int'(pkt_done) + int'(pkt_err), 0);
    reset = 1'b0;

    // RRQ with an idle cycle inside the filename
    clr_stats(); build_rrq();
    set_exp(43, 44, 1); set_exp(45, 53, 4); set_exp(54, 59, 5);
    run_frame(50);
    cmp_frame("rrq", 62);
    chk("rrq_done", n_done, 1);
    chk("rrq_err", n_err, 0);
    chk("rrq_pkt_type", done_type, 1);
    chk("rrq_gap_hold", gap_bad, 0);
    idle_after("rrq");

    clr_stats(); build_ack();
    set_exp(43, 44, 1); set_exp(45, 46, 2);
    run_frame(0);
    cmp_frame("ack", 60);
    chk("ack_done", n_done, 1);
    chk("ack_err", n_err, 0);
    chk("ack_pkt_type", done_type, 4);
    idle_after("ack");

    clr_stats(); push_hdr();
    frm.push_back(8'h00); frm.push_back(8'h03); frm.push_back(8'h00); frm.push_back(8'h01);
    for (int i = 0; i < 512; i++) frm.push_back(8'(i * 7 + 1));
    set_exp(43, 44, 1); set_exp(45, 46, 2); set_exp(47, 558, 6);
    run_frame(0);
    cmp_frame("data512", 558);
    chk("data512_done", n_done, 1);
    chk("data512_err", n_err, 0);
    chk("data512_pkt_type", done_type, 3);

    clr_stats(); push_hdr();
    frm.push_back(8'h00); frm.push_back(8'h03); frm.push_back(8'h00); frm.push_back(8'h01);
    set_exp(43, 44, 1); set_exp(45, 46, 2);
    run_frame(0);
    cmp_frame("data0", 46);
    chk("data0_done", n_done, 1);
    chk("data0_err", n_err, 0);

    clr_stats(); push_hdr();
    frm.push_back(8'h00); frm.push_back(8'h09); pad_to(60);
    set_exp(43, 44, 1);
    run_frame(0);
    cmp_frame("badop", 60);
    chk("badop_done", n_done, 0);
    chk("badop_err", n_err, 1);

    clr_stats(); push_hdr();
    frm.push_back(8'h00); frm.push_back(8'h05); frm.push_back(8'h00);
    set_exp(43, 44, 1); set_exp(45, 45, 3);
    run_frame(0);
    cmp_frame("errtrunc", 45);
    chk("errtrunc_done", n_done, 0);
    chk("errtrunc_err", n_err, 1);

    clr_stats(); push_hdr();
    frm.push_back(8'h00); frm.push_back(8'h05); frm.push_back(8'h00); frm.push_back(8'h01);
    push_str("oops"); pad_to(60);
    set_exp(43, 44, 1); set_exp(45, 46, 3); set_exp(47, 51, 7);
    run_frame(0);
    cmp_frame("errpkt", 60);
    chk("errpkt_done", n_done, 1);
    chk("errpkt_pkt_type", done_type, 5);

    // 300-byte filename: 255 bytes flagged, the rest drained
    clr_stats(); push_hdr();
    frm.push_back(8'h00); frm.push_back(8'h01);
    for (int i = 0; i < 300; i++) frm.push_back(8'h61);
    push_str("octet");
    set_exp(43, 44, 1); set_exp(45, 299, 4);
    run_frame(0);
    cmp_frame("longname", frm.size());
    chk("longname_done", n_done, 0);
    chk("longname_err", n_err, 1);

    // reset lands on byte 50 of an RRQ
    clr_stats(); build_rrq();
    for (int i = 0; i < 49; i++) drive_byte(i + 1, frm[i], 1'b0);
    reset = 1'b1; byte_valid = 1'b1; cnt = 11'd50; eth_data = frm[49];
    @(posedge clk); #1;
    reset = 1'b0; byte_valid = 1'b0;
    chk("midrst_idle_en", int'(idle_en), 1);
    chk("midrst_flags", classify(), 0);
    chk("midrst_byte_q_valid", int'(byte_q_valid), 0);
    chk("midrst_pulses", int'(pkt_done) + int'(pkt_err), 0);
    n_done = 0; n_err = 0;
    for (int i = 50; i < 62; i++) drive_byte(i + 1, frm[i], i == 61);
    begin
      int flagged = 0;
      for (int i = 51; i <= 62; i++) if (obs_cls[i] != 0) flagged++;
      chk("midrst_tail_flags", flagged, 0);
    end
    chk("midrst_tail_pulses", n_done + n_err, 0);
    clr_stats(); build_ack();
    set_exp(43, 44, 1); set_exp(45, 46, 2);
    run_frame(0);
    cmp_frame("postrst_ack", 60);
    chk("postrst_ack_done", n_done, 1);

    // RRQ abandoned at byte 48 by a new frame starting at cnt 1
    clr_stats(); build_rrq();
    for (int i = 0; i < 48; i++) drive_byte(i + 1, frm[i], 1'b0);
    build_ack();
    set_exp(43, 44, 1); set_exp(45, 46, 2);
    run_frame(0);
    cmp_frame("restart_ack", 60);
    chk("restart_done", n_done, 1);
    chk("restart_err", n_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/tftp_rx_field_decoder.md
TFTP_RX_FIELD_DECODER -- requirements
Module: tftp_rx_field_decoder

Interface
REQ-001 SHALL have parameter HDR_LEN, default 42, meaning Ethernet+IPv4+UDP header bytes ahead of the TFTP opcode.
REQ-002 SHALL have parameter CNT_W, default 11, meaning width of cnt (frames up to 2047 bytes).
REQ-003 SHALL have parameter MAX_STR, default 255, meaning maximum string field length including the 0x00 terminator.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-005 byte_valid  in  1  eth_data and cnt are valid this cycle.
REQ-006 cnt  in  CNT_W  1-based position of the current byte in the frame.
REQ-007 eth_data  in  8  current frame byte.
REQ-008 frame_end  in  1  current valid byte is the last byte of the frame.
REQ-009 byte_q / byte_q_valid  out  8 / 1  eth_data / byte_valid delayed one cycle, aligned with all *_en flags.
REQ-010 idle_en, opcode_en, blockno_en, errcode_en, filename_en, mode_en, data_en, errmsg_en  out  1 each  field class of byte_q; at most one asserted.
REQ-011 pkt_type  out  3  opcode[2:0] of the current packet; valid from the cycle after OP_LO is flagged until the next frame starts.
REQ-012 pkt_done / pkt_err  out  1 / 1  single-cycle pulses at the end of a packet decode.

Function
REQ-013 All flags SHALL be registered; byte N accepted at edge k SHALL be classified on the outputs during cycle k+1 (one-cycle latency).
REQ-014 Cycles with byte_valid=0 SHALL hold state; byte_q_valid=0 and all *_en=0 except idle_en, which follows the state.
REQ-015 States: IDLE, HDR, OP_HI, OP_LO, BLK_HI, BLK_LO, ERR_HI, ERR_LO, FNAME, MODE, DATA, EMSG, DRAIN.
REQ-016 IDLE/HDR: bytes with cnt<=HDR_LEN SHALL be class HDR (all *_en=0); cnt==HDR_LEN+1 SHALL be OP_HI.
REQ-017 OP_HI, OP_LO SHALL assert opcode_en; OP_HI!=0x00 or OP_LO outside 1..5 SHALL set the error condition and enter DRAIN.
REQ-018 Opcode 1 (RRQ) or 2 (WRQ) SHALL be followed by FNAME (filename_en) up to and including the first 0x00, then MODE (mode_en) up to and including the next 0x00, then DRAIN.
REQ-019 Opcode 3 (DATA) SHALL be followed by BLK_HI/BLK_LO (blockno_en), then DATA (data_en) until frame_end; zero payload bytes is legal.
REQ-020 Opcode 4 (ACK) SHALL be followed by BLK_HI/BLK_LO (blockno_en), then DRAIN.
REQ-021 Opcode 5 (ERROR) SHALL be followed by ERR_HI/ERR_LO (errcode_en), then EMSG (errmsg_en) up to and including 0x00, then DRAIN.
REQ-022 DRAIN bytes (padding, FCS) SHALL assert no *_en flag.
REQ-023 A string field reaching MAX_STR bytes without a terminator SHALL set the error condition and enter DRAIN.
REQ-024 frame_end accepted in any state other than DATA or DRAIN (truncated packet) SHALL set the error condition.
REQ-025 On frame_end the FSM SHALL return to IDLE; pkt_done (no error) or pkt_err (error) SHALL pulse in the cycle byte_q holds that last byte; never both.
REQ-026 A byte with cnt==1 in any state SHALL restart decoding as a new frame (HDR) and discard the prior packet without a pulse.
REQ-027 idle_en SHALL be 1 exactly when the FSM is in IDLE.

Reset
REQ-028 reset SHALL force IDLE; idle_en=1; all other outputs, byte_q, string counter and error flag =0; reset has priority over byte_valid.
REQ-029 reset mid-frame SHALL abandon the packet with no pkt_done/pkt_err pulse; the remaining bytes of that frame are classified HDR/DRAIN until frame_end.

Structure
REQ-030 Opcode constants (1..5), state encodings and default HDR_LEN SHALL live in shared package tftp_defs.
REQ-031 String length counting and terminator detection SHALL be sub-module tftp_str_field (inputs clear, byte_valid, eth_data; outputs term, overflow), reused for FNAME, MODE, EMSG.

Verification
REQ-032 RRQ, 62-byte frame, filename "test.txt\0", mode "octet\0": opcode_en for cnt 43-44, filename_en 45-53, mode_en 54-59, pkt_done once, pkt_type=1.
REQ-033 ACK, 60-byte frame, block 0x0007: opcode_en cnt 43-44, blockno_en 45-46, DRAIN 47-60, pkt_done, idle_en=1 the cycle after byte 60 is classified.
REQ-034 DATA, block 0x0001, 512 payload bytes: data_en for cnt 47-558, pkt_done, pkt_type=3; repeat with 0 payload bytes -> pkt_done, no data_en.
REQ-035 Opcode 0x0009: pkt_err pulse, no field flag after cnt 44; ERROR opcode 5 frame ending at cnt 45 -> pkt_err.
REQ-036 Filename of 300 bytes with MAX_STR=255: filename_en for 255 bytes then DRAIN, pkt_err at frame_end.
REQ-037 reset asserted at cnt 50 of an RRQ: next cycle idle_en=1, all flags 0, no pulse; following ACK frame decodes normally.
